// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one rising-edge
// write port, optional hardwired zero register and a per-register busy scoreboard.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             ra_ready,
  output logic             rb_ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_waw,
  output logic [AW:0]      busy_cnt
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             wr_ok;

  assign wr_ok = wr_en & ~(ZR & (wr_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Reservation is applied after the writeback clear so a same-cycle
  // reserve of the register being written leaves it busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (rsv_en && (rsv_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    if (ZR) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // The zero register takes priority over forwarding of an (ignored) write.
  always_comb begin
    ra_data  = regs_q[ra_addr];
    ra_ready = ~busy_q[ra_addr];
    if (ZR && (ra_addr == '0)) begin
      ra_data  = '0;
      ra_ready = 1'b1;
    end else if (BP && wr_en && (wr_addr == ra_addr)) begin
      ra_data  = wr_data;
      ra_ready = 1'b1;
    end
  end

  always_comb begin
    rb_data  = regs_q[rb_addr];
    rb_ready = ~busy_q[rb_addr];
    if (ZR && (rb_addr == '0)) begin
      rb_data  = '0;
      rb_ready = 1'b1;
    end else if (BP && wr_en && (wr_addr == rb_addr)) begin
      rb_data  = wr_data;
      rb_ready = 1'b1;
    end
  end

  assign rsv_waw  = rsv_en & busy_q[rsv_addr] & ~(wr_en & (wr_addr == rsv_addr))
                  & ~(ZR & (rsv_addr == '0));
  assign busy_cnt = busy_cnt_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the MIPS register file.
- Holds DEPTH words of WIDTH bits, with two binary-addressed combinational read ports, one synchronous write port and register 0 hardwired to zero (selectable).
- Adds a per-register busy scoreboard: issue reserves a destination, writeback clears it, and each read port reports whether its operand is ready.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the pipelined datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- AW, 5, address width; must equal log2(DEPTH).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy; when 0 it is an ordinary register.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra_addr  in  AW  read port A address.
- rb_addr  in  AW  read port B address.
- ra_data  out  WIDTH  read port A data, combinational.
- rb_data  out  WIDTH  read port B data, combinational.
- ra_ready  out  1  port A operand valid (not busy, or bypassed).
- rb_ready  out  1  port B operand valid.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- rsv_waw  out  1  combinational; rsv_en asserted while rsv_addr is already busy.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asynchronous):
  - all registers are 0;
  - all busy bits are 0;
  - busy_cnt is 0.
  - Outputs during reset follow from the cleared state: data 0, ready 1, rsv_waw = 0 unless rsv_en targets a busy register (impossible after clear).
  - Reset mid-operation discards all reservations and any same-cycle write.
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data. This is a rising-edge write; the previous generation wrote on negedge.
  - Ignored when ZERO_REG=1 and wr_addr=0.
- Read, combinational, zero latency:
  - ra_data = reg[ra_addr].
  - If ZERO_REG=1 and ra_addr=0: ra_data = 0 and ra_ready = 1, regardless of wr_en or busy.
  - Else if BYPASS=1, wr_en=1 and wr_addr=ra_addr: ra_data = wr_data and ra_ready = 1.
  - Else ra_ready = ~busy[ra_addr].
  - Port B is identical. Both ports may address the same register.
- Scoreboard update (posedge), applied per register index i:
  - set when rsv_en & rsv_addr=i;
  - clear when wr_en & wr_addr=i;
  - set and clear on the same index in the same cycle: busy stays 1 (the new reservation wins; the write data still lands).
  - Reservation of register 0 is ignored when ZERO_REG=1.
  - A write to a non-busy register is legal; busy stays 0.
- rsv_waw = rsv_en & busy[rsv_addr] & ~(wr_en & wr_addr=rsv_addr), and 0 for register 0 when ZERO_REG=1.
  - This is advisory only: the reservation is still taken and busy stays 1.
- busy_cnt is the registered popcount of the busy bits, updated in the same edge as the bits.
  - Net change per cycle is -1, 0 or +1.
  - Never exceeds DEPTH-1 when ZERO_REG=1, or DEPTH otherwise; no wrap.
- With BYPASS=0, a read of the register being written returns old data and ready = ~busy until the edge.

Test Plan:
- Reset state: drive rst_n=0 mid-cycle after writing reg5=0xDEADBEEF and reserving r7 -> immediately ra_addr=5 gives ra_data=0; ra_addr=7 gives ra_ready=1; busy_cnt=0.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, plus rsv_en on r0 -> next cycle ra_addr=0 gives 0, ready=1, busy_cnt unchanged.
- Scoreboard flow:
  - reserve r3 -> next cycle ra_addr=3 gives ra_ready=0 and busy_cnt=1;
  - then wr r3=0x12345678 -> during that cycle ra_ready=1, ra_data=0x12345678 (bypass);
  - after the edge busy_cnt=0, ready=1 and the data is held.
- Simultaneous write and reserve on r9 (wr_data=0xA5A5A5A5): after the edge reg9=0xA5A5A5A5, busy[9]=1, busy_cnt unchanged, rsv_waw=0 if r9 was busy before (write clears).
- WAW flag: reserve r4, then reserve r4 again with no write -> rsv_waw=1 in the second cycle, busy_cnt stays 1.
- Parameter sweep (WIDTH=16, DEPTH=8, AW=3, BYPASS=0):
  - reserve all r1..r7 -> busy_cnt=7;
  - write r2=0x00FF -> same cycle rb_addr=2 gives old data 0 and ready=0; next cycle 0x00FF, ready=1, busy_cnt=6.
